// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide engine.
// The op codes are also used by the control unit.
package mult_div_unit_pkg;

  localparam int          MD_WIDTH   = 32;
  localparam logic [31:0] MD_DIV0_LO = 32'hFFFF_FFFF;
  localparam logic [4:0]  MD_LAST    = 5'd31;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } md_state_e;

  function automatic logic md_is_div(md_op_e op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the pipeline
// and the multiply/divide engine.
interface mult_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        cancel;
  logic        busy;
  logic        write_HI_LO;
  logic [31:0] HI_out;
  logic [31:0] LO_out;
  logic        div_by_zero;

  modport master (
    output start, op, operand_a, operand_b, cancel,
    input  busy, write_HI_LO, HI_out, LO_out, div_by_zero
  );

  modport slave (
    input  start, op, operand_a, operand_b, cancel,
    output busy, write_HI_LO, HI_out, LO_out, div_by_zero
  );
endinterface

// File: rtl/md_sign_mag.sv
// Conditional two's-complement negate; used both
// for operand magnitudes and result sign fix-up.
module md_sign_mag #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? -val_i : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU engine
// driving the HI/LO register-file write port.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int          DATA_WIDTH = MD_WIDTH,
  parameter logic [31:0] DIV0_LO    = MD_DIV0_LO
) (
  input logic            clock,
  input logic            reset,
  mult_div_unit_if.slave md
);

  localparam int W = DATA_WIDTH;

  md_state_e state_q, state_d;

  logic [4:0]     cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           div_q, div_d;
  logic           sa_q, sa_d;
  logic           sb_q, sb_d;
  logic           dz_q, dz_d;

  md_op_e       op_in;
  logic         div_in;
  logic         sgn_in;
  logic         div0_in;
  logic         accept;
  logic         calc_go;
  logic         fix_go;
  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag;

  assign op_in   = md_op_e'(md.op);
  assign div_in  = md_is_div(op_in);
  assign sgn_in  = md_is_signed(op_in);
  assign div0_in = div_in & (md.operand_b == '0);

  // cancel only drops a request while idle, never in DONE
  assign accept = md.start &
                  (((state_q == S_IDLE) & ~md.cancel) |
                   (state_q == S_DONE));
  assign calc_go = (state_q == S_CALC) & ~md.cancel;
  assign fix_go  = (state_q == S_FIX) & ~md.cancel;

  md_sign_mag #(.W(W)) u_abs_a (
    .val_i (md.operand_a),
    .neg_i (sgn_in & md.operand_a[W-1]),
    .res_o (a_mag)
  );

  md_sign_mag #(.W(W)) u_abs_b (
    .val_i (md.operand_b),
    .neg_i (sgn_in & md.operand_b[W-1]),
    .res_o (b_mag)
  );

  // multiply step: shift-add into the upper half
  logic [W:0]     msum;
  logic [2*W-1:0] mul_nx;

  assign msum   = {1'b0, acc_q[2*W-1:W]} +
                  (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_nx = {msum, acc_q[W-1:1]};

  // divide step: restoring, 33-bit partial remainder
  logic [W:0]     rsh;
  logic [W:0]     diff;
  logic           qbit;
  logic [W-1:0]   rnew;
  logic [2*W-1:0] div_nx;

  assign rsh    = {acc_q[2*W-1:W], acc_q[W-1]};
  assign qbit   = rsh >= {1'b0, opnd_q};
  assign diff   = rsh - {1'b0, opnd_q};
  assign rnew   = qbit ? diff[W-1:0] : rsh[W-1:0];
  assign div_nx = {rnew, acc_q[W-2:0], qbit};

  logic unused;
  assign unused = diff[W];

  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix;
  logic [W-1:0]   rem_fix;
  logic [2*W-1:0] res_fix;

  md_sign_mag #(.W(2*W)) u_fix_p (
    .val_i (acc_q),
    .neg_i (sa_q ^ sb_q),
    .res_o (prod_fix)
  );

  md_sign_mag #(.W(W)) u_fix_q (
    .val_i (acc_q[W-1:0]),
    .neg_i (sa_q ^ sb_q),
    .res_o (quot_fix)
  );

  md_sign_mag #(.W(W)) u_fix_r (
    .val_i (acc_q[2*W-1:W]),
    .neg_i (sa_q),
    .res_o (rem_fix)
  );

  assign res_fix = div_q ? {rem_fix, quot_fix} : prod_fix;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) state_d = div0_in ? S_FIX : S_CALC;
        else        state_d = S_IDLE;
      end
      S_CALC: begin
        if (md.cancel)         state_d = S_IDLE;
        else if (cnt_q == '0)  state_d = S_FIX;
      end
      S_FIX: begin
        if (md.cancel)         state_d = S_IDLE;
        else if (cnt_q == '0)  state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    md.busy        = 1'b0;
    md.write_HI_LO = 1'b0;
    md.div_by_zero = 1'b0;
    unique case (state_q)
      S_CALC, S_FIX: md.busy = 1'b1;
      S_DONE: begin
        md.write_HI_LO = 1'b1;
        md.div_by_zero = dz_q;
      end
      default: ;
    endcase
  end

  assign md.HI_out = hi_q;
  assign md.LO_out = lo_q;

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    dz_d   = dz_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    unique case (1'b1)
      accept: begin
        div_d = div_in;
        sa_d  = sgn_in & md.operand_a[W-1];
        sb_d  = sgn_in & md.operand_b[W-1];
        dz_d  = div0_in;
        if (div0_in) begin
          acc_d = {md.operand_a, DIV0_LO};
          cnt_d = '0;
        end else begin
          acc_d  = {{W{1'b0}}, div_in ? a_mag : b_mag};
          opnd_d = div_in ? b_mag : a_mag;
          cnt_d  = MD_LAST;
        end
      end
      calc_go: begin
        acc_d = div_q ? div_nx : mul_nx;
        cnt_d = (cnt_q == '0) ? 5'd1 : cnt_q - 5'd1;
      end
      // two FIX cycles: sign fix-up, then commit
      fix_go: begin
        if (cnt_q != '0) begin
          acc_d = res_fix;
          cnt_d = '0;
        end else begin
          hi_d = acc_q[2*W-1:W];
          lo_d = acc_q[W-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      dz_q   <= dz_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with a
// latency/arithmetic reference model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic clock;
  logic reset;

  mult_div_unit_if mif();

  mult_div_unit u_dut (
    .clock (clock),
    .reset (reset),
    .md    (mif)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: {div_by_zero, HI, LO}
  function automatic logic [64:0] ref_op(logic [1:0] op,
                                         logic [31:0] a,
                                         logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_MULT: begin
        p = sa * sb;
        return {1'b0, p[63:0]};
      end
      MD_MULTU: begin
        u = {32'b0, a} * {32'b0, b};
        return {1'b0, u};
      end
      MD_DIV: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  int          m_rem;
  bit          m_strobe;
  bit          m_was;
  bit          m_acc;
  logic [31:0] m_hi, m_lo;
  bit          m_dz;
  logic [64:0] m_pend;

  // edges-until-strobe model: 34 for a normal op, 1 for div-by-zero
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_rem = 0; m_strobe = 0; m_dz = 0;
      m_hi = '0; m_lo = '0; m_pend = '0;
    end else begin
      m_was = m_strobe;
      m_strobe = 0;
      m_acc = mif.start && (m_rem == 0) && (!mif.cancel || m_was);
      if (m_rem > 0) begin
        if (mif.cancel) m_rem = 0;
        else begin
          m_rem--;
          if (m_rem == 0) begin
            m_strobe = 1;
            {m_dz, m_hi, m_lo} = m_pend;
          end
        end
      end
      if (m_acc) begin
        m_pend = ref_op(mif.op, mif.operand_a, mif.operand_b);
        m_rem = m_pend[64] ? 1 : 34;
      end
    end
  end

  always @(negedge clock) begin
    chk("busy", 64'(mif.busy), 64'(m_rem > 0));
    chk("write_HI_LO", 64'(mif.write_HI_LO), 64'(m_strobe));
    chk("HI_out", 64'(mif.HI_out), 64'(m_hi));
    chk("LO_out", 64'(mif.LO_out), 64'(m_lo));
    chk("div_by_zero", 64'(mif.div_by_zero), 64'(m_strobe & m_dz));
    if (mif.write_HI_LO) strobes++;
  end

  task automatic issue(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    mif.start = 1'b1;
    mif.op = op;
    mif.operand_a = a;
    mif.operand_b = b;
    @(posedge clock);
    #1 mif.start = 1'b0;
  endtask

  task automatic wait_done(string name, int lat, logic [31:0] hi,
                           logic [31:0] lo, logic dz);
    int n;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clock);
      #1;
      if (mif.write_HI_LO) begin
        n = i;
        break;
      end
    end
    chk({name, " latency"}, 64'(n), 64'(lat));
    chk({name, " HI"}, 64'(mif.HI_out), 64'(hi));
    chk({name, " LO"}, 64'(mif.LO_out), 64'(lo));
    chk({name, " dz"}, 64'(mif.div_by_zero), 64'(dz));
  endtask

  task automatic run(string name, logic [1:0] op, logic [31:0] a,
                     logic [31:0] b, int lat, logic [31:0] hi,
                     logic [31:0] lo, logic dz);
    @(posedge clock);
    #1 issue(op, a, b);
    wait_done(name, lat, hi, lo, dz);
  endtask

  int s0;

  initial begin
    reset = 1'b0;
    mif.start = 1'b0;
    mif.cancel = 1'b0;
    mif.op = 2'b00;
    mif.operand_a = '0;
    mif.operand_b = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    chk("reset busy", 64'(mif.busy), 64'd0);
    chk("reset HI", 64'(mif.HI_out), 64'd0);
    chk("reset LO", 64'(mif.LO_out), 64'd0);

    run("MULT -3*7", MD_MULT, -32'sd3, 32'd7, 34,
        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run("MULTU max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34,
        32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run("DIV -7/2", MD_DIV, -32'sd7, 32'd2, 34,
        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run("DIV ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34,
        32'h0, 32'h8000_0000, 1'b0);
    run("DIVU 1000/7", MD_DIVU, 32'd1000, 32'd7, 34,
        32'd6, 32'd142, 1'b0);
    run("DIV 7/-2", MD_DIV, 32'd7, -32'sd2, 34,
        32'd1, 32'hFFFF_FFFD, 1'b0);

    // start accepted in the DONE cycle of the previous op
    issue(MD_MULTU, 32'd6, 32'd7);
    wait_done("MULTU in DONE", 34, 32'd0, 32'd42, 1'b0);

    run("DIVU /0", MD_DIVU, 32'd100, 32'd0, 1,
        32'd100, 32'hFFFF_FFFF, 1'b1);

    // start pulse while busy is ignored
    @(posedge clock);
    #1 issue(MD_MULT, 32'd5, -32'sd9);
    repeat (3) @(posedge clock);
    #1 issue(MD_DIVU, 32'd1, 32'd0);
    wait_done("busy start", 30, 32'hFFFF_FFFF, 32'hFFFF_FFD3, 1'b0);

    run("DIVU /0 again", MD_DIVU, 32'd100, 32'd0, 1,
        32'd100, 32'hFFFF_FFFF, 1'b1);

    // cancel at CALC step 10
    @(posedge clock);
    #1 issue(MD_MULT, 32'd3, 32'd4);
    repeat (10) @(posedge clock);
    #1 mif.cancel = 1'b1;
    s0 = strobes;
    @(posedge clock);
    #1 mif.cancel = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    chk("cancel strobes", 64'(strobes - s0), 64'd0);
    chk("cancel busy", 64'(mif.busy), 64'd0);
    chk("cancel HI", 64'(mif.HI_out), 64'd100);
    chk("cancel LO", 64'(mif.LO_out), 64'hFFFF_FFFF);
    run("MULT after cancel", MD_MULT, 32'd3, 32'd4, 34,
        32'd0, 32'd12, 1'b0);

    // cancel and start together while idle
    @(posedge clock);
    #1 mif.cancel = 1'b1;
    issue(MD_MULT, 32'd2, 32'd2);
    mif.cancel = 1'b0;
    chk("cancel+start busy", 64'(mif.busy), 64'd0);

    // async reset mid-CALC, off-edge
    @(posedge clock);
    #1 issue(MD_MULTU, 32'd7, 32'd9);
    repeat (5) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    chk("rst busy", 64'(mif.busy), 64'd0);
    chk("rst HI", 64'(mif.HI_out), 64'd0);
    chk("rst LO", 64'(mif.LO_out), 64'd0);
    chk("rst strobe", 64'(mif.write_HI_LO), 64'd0);
    @(negedge clock);
    #2 reset = 1'b1;
    s0 = strobes;
    repeat (40) @(posedge clock);
    #1 chk("rst no strobe", 64'(strobes - s0), 64'd0);

    run("MULT after rst", MD_MULT, -32'sd1, -32'sd1, 34,
        32'd0, 32'd1, 1'b0);

    repeat (2) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
